handshake_input: RTL and testbench

Sink stage for the 8-bit valid/ready counting stream produced by the handshake output stage. It accepts beats through a registered-ready 2-entry skid buffer and drains them with a pseudo-random (LFSR-gated) consume pattern, which exercises upstream backpressure. It checks that consecutive values increment by one modulo 256 and exposes beat-count and error status. It is the terminal stage of the handshake pattern pair.

---
 rtl/handshake_pkg.sv | 24 ++
 rtl/handshake_input_if.sv | 14 +
 rtl/handshake_skid.sv | 65 ++++++
 rtl/handshake_input.sv | 103 ++++++++++
 tb/tb_handshake_input.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/handshake_pkg.sv
// Shared definitions for the handshake pattern pair: value width, checker
// states, LFSR geometry and the LFSR step function.
// Imported by the interface, the skid buffer user and the sink top level.
package handshake_pkg;

  localparam int VALUE_W = 8;
  localparam int COUNT_W = 16;
  localparam int LFSR_W  = 16;

  // Fibonacci taps 16,14,13,11 -> bit positions 15,13,12,10.
  localparam logic [LFSR_W-1:0] LFSR_TAPS         = 16'hB400;
  localparam logic [LFSR_W-1:0] LFSR_SEED_DEFAULT = 16'hACE1;

  typedef enum logic [1:0] {
    S_SYNC  = 2'd0,
    S_TRACK = 2'd1,
    S_FAULT = 2'd2
  } chk_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
    return {cur[LFSR_W-2:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/handshake_input_if.sv
// Valid/ready stream carrying the counting pattern between output and input stages.
// Ports: i_value/i_valid driven by the producer (master), o_ready by the sink (slave).
// No logic; o_ready is registered inside the sink.
interface handshake_input_if;
  import handshake_pkg::*;

  logic [VALUE_W-1:0] i_value;
  logic               i_valid;
  logic               o_ready;

  modport master (output i_value, output i_valid, input o_ready);
  modport slave  (input i_value, input i_valid, output o_ready);

endinterface

// File: rtl/handshake_skid.sv
// Purpose: 2-entry in-order skid buffer with a registered upstream ready.
// Latency: a beat accepted at edge N is presented on out_* during cycle N+1.
// Backpressure: in_ready = ~full of the next state, so the upstream never
// overruns; out_valid is simply "non-empty" and out_ready pops the head.
// Ports: clock, reset_n (async, active-low); in_data/in_valid/in_ready upstream;
// out_data/out_valid/out_ready downstream.
module handshake_skid #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   fill;
  logic [1:0]   fill_next;
  logic         push;
  logic         pop;

  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_valid = (fill != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_comb begin
    fill_next = fill;
    if (push && !pop) begin
      fill_next = fill + 2'd1;
    end else if (pop && !push) begin
      fill_next = fill - 2'd1;
    end
  end

  // Ready looks at the next fill level so it is a plain flop yet never lets
  // a third beat in; push on a full buffer is therefore impossible.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      fill     <= 2'd0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fill     <= fill_next;
      in_ready <= (fill_next != 2'd2);
    end
  end

  // Payload storage needs no reset: fill gates every read.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

endmodule

// File: rtl/handshake_input.sv
// Purpose: terminal sink of the counting stream; checks +1 (mod 256) sequence.
// Latency: beat accepted at edge N is consumed at edge N+1 when unstalled;
// status outputs reflect it after that edge.
// Backpressure: registered o_ready from a 2-entry skid buffer, drained every
// cycle (STALL_EN=0) or on LFSR-gated ticks of about 7/8 duty (STALL_EN=1).
// Ports: clock, reset_n (async, active-low); up (stream, slave side);
// i_clear (sync clear of checker/stats); o_count (saturating beat count);
// o_last (last consumed value); o_error (sticky); o_sync (checker tracking).
module handshake_input
  import handshake_pkg::*;
#(
  parameter bit                STALL_EN  = 1'b1,
  parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  handshake_input_if.slave   up,
  input  logic               i_clear,
  output logic [COUNT_W-1:0] o_count,
  output logic [VALUE_W-1:0] o_last,
  output logic               o_error,
  output logic               o_sync
);

  logic [LFSR_W-1:0]  lfsr;
  logic               tick;
  logic [VALUE_W-1:0] head;
  logic               head_valid;
  logic               consume;
  logic [VALUE_W-1:0] expected;
  chk_state_t         state;

  handshake_skid #(.W(VALUE_W)) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (up.i_value),
    .in_valid  (up.i_valid),
    .in_ready  (up.o_ready),
    .out_data  (head),
    .out_valid (head_valid),
    .out_ready (tick)
  );

  // Free-running stall pattern; advances regardless of traffic or clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  assign tick    = STALL_EN ? (lfsr[2:0] != 3'b000) : 1'b1;
  assign consume = head_valid & tick;

  // Checker and statistics. Clear takes priority over a coincident consume:
  // the beat still leaves the buffer (tick drives the pop) but is not counted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_SYNC;
      expected <= '0;
      o_count  <= '0;
      o_last   <= '0;
      o_error  <= 1'b0;
      o_sync   <= 1'b0;
    end else if (i_clear) begin
      state    <= S_SYNC;
      o_count  <= '0;
      o_last   <= '0;
      o_error  <= 1'b0;
      o_sync   <= 1'b0;
    end else if (consume) begin
      o_last <= head;
      if (o_count != '1) begin
        o_count <= o_count + 1'b1;
      end
      case (state)
        S_SYNC: begin
          expected <= head + 1'b1;
          state    <= S_TRACK;
          o_sync   <= 1'b1;
        end
        S_TRACK: begin
          if (head == expected) begin
            expected <= head + 1'b1;
          end else begin
            o_error <= 1'b1;
            state   <= S_FAULT;
            o_sync  <= 1'b0;
          end
        end
        S_FAULT: begin
          // Held until clear; beats are counted but not checked.
        end
        default: begin
          state  <= S_SYNC;
          o_sync <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_input.sv
module tb_handshake_input;
  import handshake_pkg::*;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst0_n, rst1_n, clr0, clr1;
  logic [15:0] cnt0, cnt1;
  logic [7:0]  last0, last1;
  logic        err0, err1, sync0, sync1;

  handshake_input_if if0 ();
  handshake_input_if if1 ();

  handshake_input #(.STALL_EN(1'b0), .LFSR_SEED(16'hACE1)) dut0 (
    .clock(clock), .reset_n(rst0_n), .up(if0), .i_clear(clr0),
    .o_count(cnt0), .o_last(last0), .o_error(err0), .o_sync(sync0)
  );

  handshake_input #(.STALL_EN(1'b1), .LFSR_SEED(16'hACE1)) dut1 (
    .clock(clock), .reset_n(rst1_n), .up(if1), .i_clear(clr1),
    .o_count(cnt1), .o_last(last1), .o_error(err1), .o_sync(sync1)
  );

  int total = 0;
  int bad   = 0;
  int low0  = 0;
  int low1  = 0;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [15:0] prev0 = 16'd0;
  logic [15:0] prev1 = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic send(input int which, input logic [7:0] v, input bit track);
    int n;
    n = 0;
    if (which == 0) begin if0.i_value = v; if0.i_valid = 1'b1; end
    else            begin if1.i_value = v; if1.i_valid = 1'b1; end
    while (((which == 0) ? !if0.o_ready : !if1.o_ready) && n < 64) begin
      if (which == 0) low0++; else low1++;
      @(negedge clock);
      n++;
    end
    if (n >= 64) begin
      total++; bad++;
      $display("FAIL send_timeout: o_ready low for 64 cycles, value %0h", v);
    end else if (track) begin
      if (which == 0) q0.push_back(v); else q1.push_back(v);
    end
    @(negedge clock);
  endtask

  task automatic idle(input int which, input int cycles);
    if (which == 0) if0.i_valid = 1'b0; else if1.i_valid = 1'b0;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic pulse_clear0();
    clr0 = 1'b1;
    @(negedge clock);
    clr0 = 1'b0;
  endtask

  // Scoreboard monitors: every +1 step of o_count is one consumed beat whose
  // value must be the next expected entry.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (cnt0 != prev0) begin
        if (cnt0 == prev0 + 16'd1) begin
          if (q0.size() == 0) begin
            total++; bad++;
            $display("FAIL mon0_extra: consumed %0h with nothing expected", last0);
          end else begin
            e = q0.pop_front();
            check("mon0_value", last0, e);
          end
        end else if (cnt0 != 16'd0) begin
          total++; bad++;
          $display("FAIL mon0_jump: count %0h after %0h", cnt0, prev0);
        end
        prev0 = cnt0;
      end
    end
  end

  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (cnt1 != prev1) begin
        if (cnt1 == prev1 + 16'd1) begin
          if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL mon1_extra: consumed %0h with nothing expected", last1);
          end else begin
            e = q1.pop_front();
            check("mon1_value", last1, e);
          end
        end else if (cnt1 != 16'd0) begin
          total++; bad++;
          $display("FAIL mon1_jump: count %0h after %0h", cnt1, prev1);
        end
        prev1 = cnt1;
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    bit found;
    rst0_n = 1'b0; rst1_n = 1'b0; clr0 = 1'b0; clr1 = 1'b0;
    if0.i_valid = 1'b0; if0.i_value = 8'd0;
    if1.i_valid = 1'b0; if1.i_value = 8'd0;
    repeat (3) @(negedge clock);

    check("rst_ready0", if0.o_ready, 1'b0);
    check("rst_count0", cnt0, 16'd0);
    check("rst_last0",  last0, 8'd0);
    check("rst_error0", err0, 1'b0);
    check("rst_sync0",  sync0, 1'b0);
    check("rst_ready1", if1.o_ready, 1'b0);
    check("rst_count1", cnt1, 16'd0);

    rst0_n = 1'b1; rst1_n = 1'b1;
    @(negedge clock);
    check("ready_rise0", if0.o_ready, 1'b1);
    check("ready_rise1", if1.o_ready, 1'b1);

    // Continuous 1..20, no stalls.
    low0 = 0;
    for (int k = 1; k <= 20; k++) send(0, 8'(k), 1'b1);
    check("t1_latency_count", cnt0, 16'd19);
    idle(0, 3);
    check("t1_ready_never_low", low0, 0);
    check("t1_count", cnt0, 16'd20);
    check("t1_last",  last0, 8'd20);
    check("t1_error", err0, 1'b0);
    check("t1_sync",  sync0, 1'b1);

    // Wrap FE,FF,00,01.
    pulse_clear0();
    check("clr_count", cnt0, 16'd0);
    check("clr_last",  last0, 8'd0);
    check("clr_sync",  sync0, 1'b0);
    send(0, 8'hFE, 1'b1); send(0, 8'hFF, 1'b1);
    send(0, 8'h00, 1'b1); send(0, 8'h01, 1'b1);
    idle(0, 3);
    check("t2_error", err0, 1'b0);
    check("t2_last",  last0, 8'h01);
    check("t2_count", cnt0, 16'd4);

    // Sequence break 5,6,8 then 9.
    pulse_clear0();
    send(0, 8'd5, 1'b1); send(0, 8'd6, 1'b1); send(0, 8'd8, 1'b1);
    idle(0, 3);
    check("t3_error_at_8", err0, 1'b1);
    check("t3_sync_at_8",  sync0, 1'b0);
    check("t3_count_at_8", cnt0, 16'd3);
    send(0, 8'd9, 1'b1);
    idle(0, 3);
    check("t3_count", cnt0, 16'd4);
    check("t3_error_sticky", err0, 1'b1);
    pulse_clear0();
    check("t3_clear_error", err0, 1'b0);
    send(0, 8'd20, 1'b1); send(0, 8'd21, 1'b1);
    idle(0, 3);
    check("t3b_error", err0, 1'b0);
    check("t3b_count", cnt0, 16'd2);
    check("t3b_sync",  sync0, 1'b1);

    // Clear coinciding with a consume: beat dropped from statistics.
    send(0, 8'd99, 1'b0);
    if0.i_valid = 1'b0;
    clr0 = 1'b1;
    @(negedge clock);
    clr0 = 1'b0;
    idle(0, 2);
    check("clrwin_count", cnt0, 16'd0);
    check("clrwin_last",  last0, 8'd0);
    check("clrwin_sync",  sync0, 1'b0);
    send(0, 8'd40, 1'b1);
    idle(0, 3);
    check("clrwin_next_count", cnt0, 16'd1);
    check("clrwin_next_last",  last0, 8'd40);
    check("clrwin_next_sync",  sync0, 1'b1);

    // Saturation: 65534 beats, then 3 more.
    pulse_clear0();
    for (int k = 0; k < 65534; k++) send(0, 8'(k), 1'b1);
    idle(0, 3);
    check("t5_count_fffe", cnt0, 16'hFFFE);
    send(0, 8'hFE, 1'b1); send(0, 8'hFF, 1'b0); send(0, 8'h00, 1'b0);
    idle(0, 3);
    check("t5_count_sat", cnt0, 16'hFFFF);
    check("t5_last",  last0, 8'h00);
    check("t5_error", err0, 1'b0);
    check("q0_drained", q0.size(), 0);

    // LFSR-gated drain, 1..200.
    low1 = 0;
    for (int k = 1; k <= 200; k++) send(1, 8'(k), 1'b1);
    idle(1, 12);
    check("t4_count", cnt1, 16'd200);
    check("t4_error", err1, 1'b0);
    check("t4_sync",  sync1, 1'b1);
    check("t4_ready_low_seen", (low1 != 0), 1'b1);
    check("t4_q1_drained", q1.size(), 0);

    // Keep streaming until the buffer is full (o_ready low), then reset.
    v = 8'd201;
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if1.i_value = v; if1.i_valid = 1'b1;
      if (!if1.o_ready) found = 1'b1;
      else begin q1.push_back(v); @(negedge clock); v = v + 8'd1; end
    end
    check("t6_full_found", found, 1'b1);
    rst1_n = 1'b0;
    if1.i_valid = 1'b0;
    #1;
    check("t6_rst_ready", if1.o_ready, 1'b0);
    check("t6_rst_count", cnt1, 16'd0);
    check("t6_rst_sync",  sync1, 1'b0);
    check("t6_rst_error", err1, 1'b0);
    check("t6_rst_state", dut1.state, S_SYNC);
    q1.delete();
    repeat (2) @(negedge clock);
    rst1_n = 1'b1;
    @(negedge clock);
    check("t6_ready_back", if1.o_ready, 1'b1);
    send(1, 8'd7, 1'b1);
    idle(1, 12);
    check("t6_count", cnt1, 16'd1);
    check("t6_last",  last1, 8'd7);
    check("t6_error", err1, 1'b0);
    check("t6_sync",  sync1, 1'b1);
    check("t6_q1_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
